dma_reg_if: RTL and testbench
=============================

Name: dma_reg_if

Overview:
- CPU-facing register file and program interface of the 8237A-style DMA controller.
- Decodes CPU I/O strobes on A[3:0], owns the base/current address and word-count registers plus mode, command, request, mask, temp and status registers.
- Applies per-transfer address/count updates and terminal-count (TC) handling requested by the downstream timing/control block.
- Feeds that block the selected channel's current values and the global control registers.

Parameters:
- NCH, 4, number of DMA channels (decode map fixed for 4).
- AW, 16, address and word-count register width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset, same effect as master clear.
- csN  in  1  chip select, active low.
- iorN  in  1  I/O read strobe, active low.
- iowN  in  1  I/O write strobe, active low.
- addr  in  4  register select A3..A0.
- dbIn  in  8  CPU write data.
- dbOut  out  8  CPU read data, registered.
- dbOe  out  1  high while a valid read strobe is active.
- dreq  in  4  synchronized DREQ lines, shown in status[7:4].
- updEn  in  1  one-cycle pulse requesting a transfer update.
- updCh  in  2  channel for update and for the curr* outputs.
- currAddr  out  16  current address of updCh.
- currWord  out  16  current word count of updCh.
- modeOut  out  8  mode register of updCh.
- commandOut  out  8  command register.
- maskOut  out  4  mask bits.
- requestOut  out  4  software request bits.
- tcPulse  out  1  one-cycle pulse when an update reaches TC.

Behaviour:
- Strobe qualification:
  - A write strobe starts on the first cycle with csN=0 and iowN=0, after a cycle where that condition was false.
  - Reads qualify the same way with iorN.
  - Each strobe acts exactly once, however long it is held.
  - If both strobes are low, neither acts.
- Write map, applied on the write-start cycle:
  - 0,2,4,6: address of channel addr[2:1], byte selected by the byte-pointer flip-flop (FF). Writes base and current together.
  - 1,3,5,7: word count, same byte and base/current rules.
  - Toggle FF after every write to 0–7.
  - 8: command := dbIn.
  - 9: request[dbIn[1:0]] := dbIn[2].
  - A: mask[dbIn[1:0]] := dbIn[2].
  - B: mode[dbIn[1:0]] := dbIn.
  - C: FF := 0.
  - D: master clear.
  - E: mask := 0.
  - F: mask := dbIn[3:0].
- Read map:
  - dbOut is latched on the read-start cycle and is valid from the next cycle until the strobe ends.
  - 0–7 return the current register byte selected by FF, then FF toggles.
  - 8 returns status, then clears status[3:0] in the same cycle.
  - D returns temp.
  - All other addresses return 0x00.
  - dbOe=1 from the cycle after read-start while the strobe is held.
- FF: 0 selects the low byte, 1 the high byte.
- Reset / master clear (next cycle):
  - command=0, request=0, status[3:0]=0, temp=0, FF=0.
  - mask=4'hF.
  - All mode=0.
  - dbOut=0, dbOe=0, tcPulse=0.
  - Address and count registers = 0.
  - Reset mid-strobe aborts the strobe. A strobe still held after reset is not re-executed.
- Update on updEn, for channel c=updCh:
  - currWord := currWord-1, wrapping mod 2^16.
  - currAddr := currAddr-1 if mode[c][5] else +1, wrapping mod 2^16.
  - TC occurs when currWord was 16'h0000 before the decrement. Then:
    - status[c]=1, tcPulse=1 next cycle, request[c]=0.
    - If mode[c][4] (autoinit): current := base for both registers, replacing the decrement/increment result.
    - Otherwise: mask[c]=1.
- status[7:4] = dreq, sampled each cycle.
- Collisions:
  - A CPU write to a channel's address or count in the same cycle as an update of that channel: the CPU byte write wins for its register; the other register still updates.
  - Status read coinciding with TC on the same bit: the new TC bit is set, and the read returns the old value.
  - Master clear overrides everything.
- Outputs currAddr, currWord, modeOut, commandOut, maskOut and requestOut are combinational from registers.

Test Plan:
- Reset, then read addr 8 and write F/E:
  - Read of addr 8 returns 0x00 when dreq=0.
  - maskOut=4'hF after reset.
  - Write F 0x05 -> maskOut=4'h5; write E -> 4'h0.
- FF sequencing:
  - Write C, then writes 0x34, 0x12 to addr 2 -> ch1 base and current = 16'h1234.
  - Reads of addr 2 return 0x34 then 0x12.
  - A held iorN produces only one FF toggle.
- Increment with TC, no autoinit:
  - ch0 mode 0x00, addr 0x1000, count 0x0001.
  - Three updEn pulses give currAddr 0x1001, then 0x1002, then 0x1003.
  - After the second pulse currWord=0xFFFF.
  - tcPulse and status[0]=1 follow the second update; maskOut[0]=1.
  - A status read returns 0x01, and the next status read returns 0x00.
- Autoinit with decrement:
  - ch3 mode 0x33, base addr 0x8000, count 0x0000.
  - One update -> TC; currAddr=0x8000 and currWord=0x0000 reloaded; mask[3] stays 0.
- Single-bit commands:
  - Write 9 with 0x06 -> requestOut=4'h4; write 9 with 0x02 -> 4'h0.
  - Write A with 0x05 -> mask[1]=1.
- Collision and master clear:
  - CPU write of low byte 0xAA to addr 0 in the same cycle as an updEn on ch0 -> currAddr low byte = 0xAA; currWord decrements.
  - Then write D -> all reset values restored next cycle.

Source files
------------

// File: rtl/dma_reg_if.sv
// dma_reg_if: CPU register file and program interface of an 8237A-style DMA controller.
// Latency: CPU writes and transfer updates land on the next clock; read data registered one cycle after read-start.
// Backpressure: none; each qualified strobe or updEn pulse is consumed on the cycle it is seen.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset (same effect as master clear)
//   csN, iorN, iowN       CPU chip select and I/O strobes, active low
//   addr, dbIn            register select A3..A0 and CPU write data
//   dbOut, dbOe           registered CPU read data and its output enable
//   dreq                  synchronized DREQ lines, reflected in status[7:4]
//   updEn, updCh          per-transfer update pulse and channel (updCh also selects the curr* view)
//   currAddr, currWord    current address / word count of updCh
//   modeOut               mode register of updCh
//   commandOut, maskOut, requestOut   global control registers
//   tcPulse               one-cycle pulse when an update hits terminal count
module dma_reg_if #(
   parameter int NCH = 4,
   parameter int AW  = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           csN,
   input  logic           iorN,
   input  logic           iowN,
   input  logic [3:0]     addr,
   input  logic [7:0]     dbIn,
   output logic [7:0]     dbOut,
   output logic           dbOe,
   input  logic [NCH-1:0] dreq,
   input  logic           updEn,
   input  logic [1:0]     updCh,
   output logic [AW-1:0]  currAddr,
   output logic [AW-1:0]  currWord,
   output logic [7:0]     modeOut,
   output logic [7:0]     commandOut,
   output logic [NCH-1:0] maskOut,
   output logic [NCH-1:0] requestOut,
   output logic           tcPulse
);

   localparam logic [AW-1:0] ONE = AW'(1);

   // ------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------
   logic [AW-1:0]  baseAddr [NCH];
   logic [AW-1:0]  baseWord [NCH];
   logic [AW-1:0]  curAddrR [NCH];
   logic [AW-1:0]  curWordR [NCH];
   logic [7:0]     mode     [NCH];
   logic [7:0]     command;
   logic [NCH-1:0] request;
   logic [NCH-1:0] mask;
   logic [NCH-1:0] statusLo;
   logic [NCH-1:0] statusHi;
   logic [7:0]     temp;
   logic           ff;
   logic           rdOeQ;

   // ------------------------------------------------------------------
   // Strobe qualification. A strobe with the other one also low is not a
   // valid access, so both conditions exclude it.
   // ------------------------------------------------------------------
   logic wrCond;
   logic rdCond;
   logic wrCondQ;
   logic rdCondQ;
   logic wrStart;
   logic rdStart;
   logic mcStart;

   assign wrCond  = ~csN & ~iowN & iorN;
   assign rdCond  = ~csN & ~iorN & iowN;
   assign wrStart = wrCond & ~wrCondQ;
   assign rdStart = rdCond & ~rdCondQ;
   assign mcStart = wrStart & (addr == 4'hD);

   logic [1:0] wrCh;
   assign wrCh = addr[2:1];

   // Replace one byte of a 16-bit register, keeping the other byte.
   function automatic logic [AW-1:0] putByte(input logic [AW-1:0] old,
                                             input logic          hi,
                                             input logic [7:0]    b);
      putByte = hi ? {b, old[7:0]} : {old[AW-1:8], b};
   endfunction

   // ------------------------------------------------------------------
   // Transfer update datapath for channel updCh
   // ------------------------------------------------------------------
   logic          updTc;
   logic [AW-1:0] updAddrNext;
   logic [AW-1:0] updWordNext;

   always_comb begin
      updTc       = (curWordR[updCh] == '0);
      updWordNext = curWordR[updCh] - ONE;
      updAddrNext = mode[updCh][5] ? (curAddrR[updCh] - ONE) : (curAddrR[updCh] + ONE);
      // Autoinit reload takes the place of the decrement/increment result.
      if (updTc && mode[updCh][4]) begin
         updAddrNext = baseAddr[updCh];
         updWordNext = baseWord[updCh];
      end
   end

   // ------------------------------------------------------------------
   // Read data mux (sampled into dbOut on read-start)
   // ------------------------------------------------------------------
   logic [AW-1:0] rdSel;
   logic [7:0]    rdData;

   always_comb begin
      rdSel  = addr[0] ? curWordR[addr[2:1]] : curAddrR[addr[2:1]];
      rdData = 8'h00;
      if (!addr[3]) begin
         rdData = ff ? rdSel[AW-1:8] : rdSel[7:0];
      end else if (addr == 4'h8) begin
         rdData = {statusHi, statusLo};
      end else if (addr == 4'hD) begin
         rdData = temp;
      end
   end

   // ------------------------------------------------------------------
   // Sequential state. Statement order inside the non-clear branch sets
   // collision priority: status clear < TC set, update < CPU write.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // Edge history always tracks the raw strobe, so a strobe held across
      // reset or master clear never restarts.
      wrCondQ  <= wrCond;
      rdCondQ  <= rdCond;
      statusHi <= dreq;

      if (reset || mcStart) begin
         command  <= '0;
         request  <= '0;
         mask     <= '1;
         statusLo <= '0;
         temp     <= '0;
         ff       <= 1'b0;
         dbOut    <= '0;
         rdOeQ    <= 1'b0;
         tcPulse  <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            baseAddr[i] <= '0;
            baseWord[i] <= '0;
            curAddrR[i] <= '0;
            curWordR[i] <= '0;
            mode[i]     <= '0;
         end
      end else begin
         tcPulse <= 1'b0;
         rdOeQ   <= rdCond & (rdStart | rdOeQ);

         if (rdStart) begin
            dbOut <= rdData;
            if (!addr[3]) begin
               ff <= ~ff;
            end
            if (addr == 4'h8) begin
               statusLo <= '0;
            end
         end

         if (updEn) begin
            curAddrR[updCh] <= updAddrNext;
            curWordR[updCh] <= updWordNext;
            if (updTc) begin
               statusLo[updCh] <= 1'b1;
               request[updCh]  <= 1'b0;
               tcPulse         <= 1'b1;
               if (!mode[updCh][4]) begin
                  mask[updCh] <= 1'b1;
               end
            end
         end

         if (wrStart) begin
            if (!addr[3]) begin
               // Byte goes into pre-update values, so a same-cycle CPU
               // write overrides the update for its own register only.
               if (addr[0]) begin
                  baseWord[wrCh] <= putByte(baseWord[wrCh], ff, dbIn);
                  curWordR[wrCh] <= putByte(curWordR[wrCh], ff, dbIn);
               end else begin
                  baseAddr[wrCh] <= putByte(baseAddr[wrCh], ff, dbIn);
                  curAddrR[wrCh] <= putByte(curAddrR[wrCh], ff, dbIn);
               end
               ff <= ~ff;
            end else begin
               case (addr[2:0])
                  3'd0:    command <= dbIn;
                  3'd1:    request[dbIn[1:0]] <= dbIn[2];
                  3'd2:    mask[dbIn[1:0]] <= dbIn[2];
                  3'd3:    mode[dbIn[1:0]] <= dbIn;
                  3'd4:    ff <= 1'b0;
                  3'd6:    mask <= '0;
                  3'd7:    mask <= dbIn[NCH-1:0];
                  default: ; // address D is master clear, handled above
               endcase
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign dbOe       = rdOeQ & rdCond;
   assign currAddr   = curAddrR[updCh];
   assign currWord   = curWordR[updCh];
   assign modeOut    = mode[updCh];
   assign commandOut = command;
   assign maskOut    = mask;
   assign requestOut = request;

endmodule

// File: tb/tb_dma_reg_if.sv
// tb_dma_reg_if: directed plus randomized checks of dma_reg_if against a behavioural model.
// Latency: one CPU access or update per two clocks, results compared on the falling edge.
// Backpressure: not applicable; the bench paces all stimulus itself.
module tb_dma_reg_if;

   logic        clk = 1'b0;
   logic        reset;
   logic        csN, iorN, iowN;
   logic [3:0]  addr;
   logic [7:0]  dbIn;
   logic [7:0]  dbOut;
   logic        dbOe;
   logic [3:0]  dreq;
   logic        updEn;
   logic [1:0]  updCh;
   logic [15:0] currAddr, currWord;
   logic [7:0]  modeOut, commandOut;
   logic [3:0]  maskOut, requestOut;
   logic        tcPulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dma_reg_if #(.NCH(4), .AW(16)) dut (
      .clk(clk), .reset(reset), .csN(csN), .iorN(iorN), .iowN(iowN),
      .addr(addr), .dbIn(dbIn), .dbOut(dbOut), .dbOe(dbOe), .dreq(dreq),
      .updEn(updEn), .updCh(updCh), .currAddr(currAddr), .currWord(currWord),
      .modeOut(modeOut), .commandOut(commandOut), .maskOut(maskOut),
      .requestOut(requestOut), .tcPulse(tcPulse)
   );

   // ---------------- behavioural model ----------------
   logic [15:0] mBaseA [4];
   logic [15:0] mBaseW [4];
   logic [15:0] mCurA  [4];
   logic [15:0] mCurW  [4];
   logic [7:0]  mMode  [4];
   logic [7:0]  mCmd;
   logic [3:0]  mReq, mMask, mStat;
   bit          mFf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] setByte(input logic [15:0] old, input bit hi, input logic [7:0] d);
      int v;
      if (hi) v = (int'(old) % 256) + int'(d) * 256;
      else    v = (int'(old) / 256) * 256 + int'(d);
      return v[15:0];
   endfunction

   task automatic mReset();
      for (int c = 0; c < 4; c++) begin
         mBaseA[c] = 0; mBaseW[c] = 0; mCurA[c] = 0; mCurW[c] = 0; mMode[c] = 0;
      end
      mCmd = 0; mReq = 0; mMask = 4'hF; mStat = 0; mFf = 0;
   endtask

   task automatic mWrite(input logic [3:0] a, input logic [7:0] d);
      int c;
      if (a < 8) begin
         c = int'(a) / 2;
         if (a % 2 == 1) begin
            mBaseW[c] = setByte(mBaseW[c], mFf, d);
            mCurW[c]  = setByte(mCurW[c], mFf, d);
         end else begin
            mBaseA[c] = setByte(mBaseA[c], mFf, d);
            mCurA[c]  = setByte(mCurA[c], mFf, d);
         end
         mFf = !mFf;
      end else begin
         c = int'(d) % 4;
         case (a)
            4'h8: mCmd = d;
            4'h9: mReq[c] = d[2];
            4'hA: mMask[c] = d[2];
            4'hB: mMode[c] = d;
            4'hC: mFf = 0;
            4'hD: mReset();
            4'hE: mMask = 0;
            default: mMask = d[3:0];
         endcase
      end
   endtask

   task automatic mUpdate(input int c, output bit tc);
      tc = (mCurW[c] == 0);
      if (tc && mMode[c][4]) begin
         mCurA[c] = mBaseA[c];
         mCurW[c] = mBaseW[c];
      end else begin
         mCurW[c] = 16'((int'(mCurW[c]) + 65535) % 65536);
         if (mMode[c][5]) mCurA[c] = 16'((int'(mCurA[c]) + 65535) % 65536);
         else             mCurA[c] = 16'((int'(mCurA[c]) + 1) % 65536);
      end
      if (tc) begin
         mStat[c] = 1'b1;
         mReq[c]  = 1'b0;
         if (!mMode[c][4]) mMask[c] = 1'b1;
      end
   endtask

   task automatic mRead(input logic [3:0] a, output logic [7:0] exp);
      int v;
      exp = 8'h00;
      if (a < 8) begin
         v = (a % 2 == 1) ? int'(mCurW[int'(a) / 2]) : int'(mCurA[int'(a) / 2]);
         exp = mFf ? 8'(v / 256) : 8'(v % 256);
         mFf = !mFf;
      end else if (a == 4'h8) begin
         exp = {dreq, mStat};
         mStat = 0;
      end
   endtask

   // ---------------- bus tasks ----------------
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      csN = 0; iowN = 0; addr = a; dbIn = d;
      mWrite(a, d);
      @(negedge clk);
      csN = 1; iowN = 1;
   endtask

   task automatic rd(input logic [3:0] a, input int hold, output logic [7:0] got);
      logic [7:0] exp;
      @(negedge clk);
      csN = 0; iorN = 0; addr = a;
      mRead(a, exp);
      @(negedge clk);
      chk("rd_oe", dbOe, 1'b1);
      got = dbOut;
      chk("rd_data", got, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("rd_hold_oe", dbOe, 1'b1);
         chk("rd_hold_data", dbOut, got);
      end
      csN = 1; iorN = 1;
      #1 chk("rd_oe_off", dbOe, 1'b0);
   endtask

   task automatic upd(input int c);
      bit tc;
      @(negedge clk);
      updEn = 1; updCh = 2'(c);
      mUpdate(c, tc);
      @(negedge clk);
      updEn = 0;
      chk("tc_pulse", tcPulse, tc);
   endtask

   task automatic chkState();
      for (int c = 0; c < 4; c++) begin
         updCh = 2'(c);
         #1;
         chk("curr_addr", currAddr, mCurA[c]);
         chk("curr_word", currWord, mCurW[c]);
         chk("mode", modeOut, mMode[c]);
      end
      chk("mask", maskOut, mMask);
      chk("request", requestOut, mReq);
      chk("command", commandOut, mCmd);
   endtask

   task automatic showCh(input int c);
      updCh = 2'(c);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] got;
      logic [3:0] a;
      logic [7:0] d;
      logic [15:0] pre;
      bit tc;
      int op;

      reset = 1; csN = 1; iorN = 1; iowN = 1; addr = 0; dbIn = 0;
      dreq = 0; updEn = 0; updCh = 0;
      mReset();
      repeat (3) @(negedge clk);
      reset = 0;

      // Reset state
      chk("rst_mask", maskOut, 4'hF);
      chk("rst_dbout", dbOut, 8'h00);
      chk("rst_dboe", dbOe, 1'b0);
      chk("rst_tc", tcPulse, 1'b0);
      chkState();
      rd(4'h8, 0, got);
      chk("rst_status", got, 8'h00);
      wr(4'hF, 8'h05);
      chk("mask_all", maskOut, 4'h5);
      wr(4'hE, 8'h00);
      chk("mask_clr", maskOut, 4'h0);

      // Byte-pointer sequencing
      wr(4'hC, 8'h00);
      wr(4'h2, 8'h34);
      wr(4'h2, 8'h12);
      showCh(1);
      chk("ch1_addr", currAddr, 16'h1234);
      rd(4'h2, 0, got);
      chk("ch1_rd_lo", got, 8'h34);
      rd(4'h2, 3, got);
      chk("ch1_rd_hi_held", got, 8'h12);
      rd(4'h2, 0, got);
      chk("ch1_rd_one_toggle", got, 8'h34);
      wr(4'hC, 8'h00);

      // Increment with TC, no autoinit
      wr(4'hB, 8'h00);
      wr(4'h0, 8'h00); wr(4'h0, 8'h10);
      wr(4'h1, 8'h01); wr(4'h1, 8'h00);
      upd(0); showCh(0);
      chk("inc1_addr", currAddr, 16'h1001);
      upd(0); showCh(0);
      chk("tc_pulse_inc", tcPulse, 1'b1);
      chk("inc2_addr", currAddr, 16'h1002);
      chk("inc2_word", currWord, 16'hFFFF);
      chk("inc2_mask0", maskOut[0], 1'b1);
      upd(0); showCh(0);
      chk("inc3_addr", currAddr, 16'h1003);
      rd(4'h8, 0, got);
      chk("status_tc0", got, 8'h01);
      rd(4'h8, 0, got);
      chk("status_clr", got, 8'h00);
      chkState();

      // Autoinit with decrement
      wr(4'hB, 8'h33);
      wr(4'h6, 8'h00); wr(4'h6, 8'h80);
      wr(4'h7, 8'h00); wr(4'h7, 8'h00);
      upd(3); showCh(3);
      chk("auto_tc", tcPulse, 1'b1);
      chk("auto_addr", currAddr, 16'h8000);
      chk("auto_word", currWord, 16'h0000);
      chk("auto_mask3", maskOut[3], 1'b0);

      // Single-bit commands
      wr(4'h9, 8'h06);
      chk("req_set", requestOut, 4'h4);
      wr(4'h9, 8'h02);
      chk("req_clr", requestOut, 4'h0);
      wr(4'hA, 8'h05);
      chk("mask_bit1", maskOut[1], 1'b1);
      chkState();

      // Collision: CPU low-byte write to ch0 address during ch0 update
      wr(4'hC, 8'h00);
      @(negedge clk);
      csN = 0; iowN = 0; addr = 4'h0; dbIn = 8'hAA;
      updEn = 1; updCh = 0;
      pre = mCurA[0];
      mUpdate(0, tc);
      mCurA[0] = pre;
      mWrite(4'h0, 8'hAA);
      @(negedge clk);
      csN = 1; iowN = 1; updEn = 0;
      showCh(0);
      chk("coll_addr", currAddr, 16'h10AA);
      chk("coll_word", currWord, 16'hFFFD);

      // Master clear
      wr(4'hD, 8'h00);
      chk("mc_mask", maskOut, 4'hF);
      chk("mc_dbout", dbOut, 8'h00);
      chkState();
      rd(4'h8, 0, got);
      chk("mc_status", got, 8'h00);

      // Reset while a write strobe is held: must not execute afterwards
      @(negedge clk);
      reset = 1; csN = 0; iowN = 0; addr = 4'hF; dbIn = 8'h03;
      @(negedge clk);
      reset = 0;
      mReset();
      repeat (2) @(negedge clk);
      csN = 1; iowN = 1;
      chk("rst_held_mask", maskOut, 4'hF);

      // Both strobes low: neither acts
      @(negedge clk);
      csN = 0; iowN = 0; iorN = 0; addr = 4'hF; dbIn = 8'h06;
      repeat (2) @(negedge clk);
      chk("both_oe", dbOe, 1'b0);
      csN = 1; iowN = 1; iorN = 1;
      chkState();

      // Randomized traffic against the model
      wr(4'hE, 8'h00);
      for (int i = 0; i < 300; i++) begin
         dreq = 4'($urandom_range(0, 15));
         @(negedge clk);
         op = $urandom_range(0, 9);
         d  = 8'($urandom_range(0, 255));
         case (op)
            0, 1, 2: begin
               a = 4'($urandom_range(0, 7));
               if (a[0] && $urandom_range(0, 1) == 1) d = 8'($urandom_range(0, 1));
               wr(a, d);
            end
            3, 9:    upd($urandom_range(0, 3));
            4:       begin
               a = 4'($urandom_range(0, 15));
               rd(a, $urandom_range(0, 2), got);
            end
            5:       wr(4'hB, d);
            6:       wr(($urandom_range(0, 1) == 1) ? 4'h9 : 4'hA, d);
            7:       begin
               op = $urandom_range(0, 2);
               wr((op == 0) ? 4'hC : (op == 1) ? 4'hE : 4'hF, d);
            end
            default: begin
               if ($urandom_range(0, 7) == 0) wr(4'hD, d);
               else                           wr(4'h8, d);
            end
         endcase
         chkState();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
